// File: rtl/bht_port_arbiter_if.sv
// Bundle of the BHT arbiter's handshake and table-port signals.
//   slave  : arbiter side (consumes lookups/updates, drives the table port and stats)
//   master : environment side (IF/EX stages, table macro, stats readers)
// Signals:
//   lookup_valid/lookup_pc/lookup_ready            IF-stage prediction read request/grant
//   lookup_rsp_valid/lookup_rsp_taken/lookup_rsp_state  lookup result, one cycle after grant
//   upd_valid/upd_pc/upd_taken/upd_mispred         EX-stage branch resolution
//   tbl_en/tbl_we/tbl_addr/tbl_wdata/tbl_rdata     single-port table, 1-cycle synchronous read
//   init_done, mispred_cnt, drop_cnt               status and statistics
interface bht_port_arbiter_if #(
  parameter int unsigned IDX_W = 4
);
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             lookup_ready;
  logic             lookup_rsp_valid;
  logic             lookup_rsp_taken;
  logic [1:0]       lookup_rsp_state;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             upd_mispred;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic             init_done;
  logic [15:0]      mispred_cnt;
  logic [7:0]       drop_cnt;

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispred, tbl_rdata,
    output lookup_ready, lookup_rsp_valid, lookup_rsp_taken, lookup_rsp_state,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done, mispred_cnt, drop_cnt
  );

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispred, tbl_rdata,
    input  lookup_ready, lookup_rsp_valid, lookup_rsp_taken, lookup_rsp_state,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done, mispred_cnt, drop_cnt
  );
endinterface

// File: rtl/bht_port_arbiter.sv
// Branch history table port arbiter. Sweeps the table to INIT_STATE after reset, then shares
// the single table port between IF-stage lookups and EX-stage 2-bit counter updates. Updates
// are queued in a small FIFO and applied as atomic read-modify-write pairs.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bht_port_arbiter_if.slave (lookup, update, table port, status/statistics)
module bht_port_arbiter #(
  parameter int unsigned IDX_W      = 4,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int unsigned DEPTH      = 2
) (
  input logic               clk,
  input logic               rst,
  bht_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           st_q, st_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             pend_q, pend_d;   // update read issued last cycle, write due now
  logic             lk_q, lk_d;       // lookup granted last cycle
  logic [IDX_W-1:0] fifo_idx_q [DEPTH];
  logic             fifo_tk_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      mispred_q;
  logic [7:0]       drop_q;

  logic             run, full, empty;
  logic             do_wr, do_lk, do_rd, push, pop, drop;
  logic [IDX_W-1:0] head_idx;
  logic             head_tk;
  logic [1:0]       new_val;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reset gates all table activity so a write pending at the reset cycle never lands.
  assign run   = (st_q == StRun) && !rst;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tk  = fifo_tk_q[rd_ptr_q];

  always_comb begin
    new_val = bus.tbl_rdata;
    if (head_tk) begin
      if (bus.tbl_rdata != 2'b11) new_val = bus.tbl_rdata + 2'b01;
    end else begin
      if (bus.tbl_rdata != 2'b00) new_val = bus.tbl_rdata - 2'b01;
    end
  end

  // Port priority: pending RMW write, then lookup, then update read. A full FIFO holds off
  // lookups so updates cannot starve.
  assign bus.lookup_ready = run && !pend_q && !full;
  assign do_wr = run && pend_q;
  assign do_lk = bus.lookup_valid && bus.lookup_ready;
  assign do_rd = run && !pend_q && !do_lk && !empty;

  assign pop  = do_wr;
  assign push = run && bus.upd_valid && (!full || pop);
  assign drop = bus.upd_valid && !push;

  always_comb begin
    bus.tbl_en    = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    st_d          = st_q;
    sweep_d       = sweep_q;
    pend_d        = do_rd;
    lk_d          = do_lk;
    unique case (st_q)
      StInit: begin
        if (!rst) begin
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = sweep_q;
          bus.tbl_wdata = INIT_STATE;
          sweep_d       = sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) st_d = StRun;
        end
      end
      StRun: begin
        if (do_wr) begin
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = head_idx;
          bus.tbl_wdata = new_val;
        end else if (do_lk) begin
          bus.tbl_en    = 1'b1;
          bus.tbl_addr  = bus.lookup_pc[IDX_W+1:2];
        end else if (do_rd) begin
          bus.tbl_en    = 1'b1;
          bus.tbl_addr  = head_idx;
        end
      end
      default: st_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StInit;
      sweep_q   <= '0;
      pend_q    <= 1'b0;
      lk_q      <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      mispred_q <= '0;
      drop_q    <= '0;
    end else begin
      st_q    <= st_d;
      sweep_q <= sweep_d;
      pend_q  <= pend_d;
      lk_q    <= lk_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (bus.upd_valid && bus.upd_mispred) mispred_q <= mispred_q + 16'd1;
      if (drop && (drop_q != 8'hff))        drop_q    <= drop_q + 8'd1;
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= bus.upd_pc[IDX_W+1:2];
      fifo_tk_q[wr_ptr_q]  <= bus.upd_taken;
    end
  end

  assign bus.lookup_rsp_valid = lk_q;
  assign bus.lookup_rsp_state = bus.tbl_rdata;
  assign bus.lookup_rsp_taken = bus.tbl_rdata[1];
  assign bus.init_done        = (st_q == StRun);
  assign bus.mispred_cnt      = mispred_q;
  assign bus.drop_cnt         = drop_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0],
                            bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_bht_port_arbiter.sv
module tb_bht_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bht_port_arbiter_if #(.IDX_W(4)) bus ();

  bht_port_arbiter #(
    .IDX_W     (4),
    .INIT_STATE(2'b01),
    .DEPTH     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Table macro model: single port, synchronous read, 1-cycle latency.
  logic [1:0] mem [16];
  always @(posedge clk) begin
    if (bus.tbl_en) begin
      if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
      else            bus.tbl_rdata     <= mem[bus.tbl_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_mispred  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.lookup_valid = 1'b1;  // must not be granted during the sweep
    bus.lookup_pc    = 32'h14;
    #1;
    check("rst_init_done", bus.init_done, 0);
    check("rst_mispred", bus.mispred_cnt, 0);
    check("rst_drop", bus.drop_cnt, 0);
    check("rst_rsp_valid", bus.lookup_rsp_valid, 0);

    // Sweep: 16 consecutive writes of 2'b01
    for (int i = 0; i < 16; i++) begin
      check("sweep_en", bus.tbl_en, 1);
      check("sweep_we", bus.tbl_we, 1);
      check("sweep_addr", bus.tbl_addr, i);
      check("sweep_wdata", bus.tbl_wdata, 2'b01);
      check("sweep_ready", bus.lookup_ready, 0);
      check("sweep_done", bus.init_done, 0);
      if (i == 15) bus.lookup_valid = 1'b0;
      tick();
      #1;
    end
    check("init_done_17", bus.init_done, 1);
    check("idle_en", bus.tbl_en, 0);

    // Lookup pc 0x14 -> index 5
    tick();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h14;
    #1;
    check("lk_ready", bus.lookup_ready, 1);
    check("lk_en", bus.tbl_en, 1);
    check("lk_we", bus.tbl_we, 0);
    check("lk_addr", bus.tbl_addr, 5);
    tick();
    bus.lookup_valid = 1'b0;
    #1;
    check("lk_rsp_valid", bus.lookup_rsp_valid, 1);
    check("lk_rsp_state", bus.lookup_rsp_state, 2'b01);
    check("lk_rsp_taken", bus.lookup_rsp_taken, 0);

    // Three taken updates to index 5 on consecutive cycles
    tick();
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h14;
    bus.upd_taken = 1'b1;
    #1;
    check("u1_push_idle", bus.tbl_en, 0);
    tick(); #1;
    check("u1_rd_en", bus.tbl_en, 1);
    check("u1_rd_we", bus.tbl_we, 0);
    check("u1_rd_addr", bus.tbl_addr, 5);
    check("u1_rsp_valid", bus.lookup_rsp_valid, 0);
    tick(); #1;
    check("u1_wr_we", bus.tbl_we, 1);
    check("u1_wr_addr", bus.tbl_addr, 5);
    check("u1_wr_data", bus.tbl_wdata, 2'b10);
    tick();
    bus.upd_valid = 1'b0;
    #1;
    check("u2_rd_en", bus.tbl_en, 1);
    check("u2_rd_we", bus.tbl_we, 0);
    tick(); #1;
    check("u2_wr_we", bus.tbl_we, 1);
    check("u2_wr_data", bus.tbl_wdata, 2'b11);
    tick(); #1;
    check("u3_rd_en", bus.tbl_en, 1);
    check("u3_rd_we", bus.tbl_we, 0);
    tick(); #1;
    check("u3_wr_we", bus.tbl_we, 1);
    check("u3_wr_addr", bus.tbl_addr, 5);
    check("u3_wr_sat", bus.tbl_wdata, 2'b11);
    tick(); #1;
    check("u3_idle_en", bus.tbl_en, 0);
    check("u3_drop", bus.drop_cnt, 0);

    // Lookups held high while updates to index 8 arrive on 3 cycles
    tick();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h14;
    bus.upd_valid    = 1'b1;
    bus.upd_pc       = 32'h20;
    bus.upd_taken    = 1'b0;
    bus.upd_mispred  = 1'b1;
    #1;
    check("b0_ready", bus.lookup_ready, 1);
    check("b0_addr", bus.tbl_addr, 5);
    check("b0_we", bus.tbl_we, 0);
    tick(); #1;
    check("b1_ready", bus.lookup_ready, 1);
    check("b1_addr", bus.tbl_addr, 5);
    check("b1_rsp_valid", bus.lookup_rsp_valid, 1);
    check("b1_rsp_state", bus.lookup_rsp_state, 2'b11);
    check("b1_rsp_taken", bus.lookup_rsp_taken, 1);
    tick();
    bus.upd_mispred = 1'b0;
    #1;
    check("b2_ready_full", bus.lookup_ready, 0);
    check("b2_rd_en", bus.tbl_en, 1);
    check("b2_rd_we", bus.tbl_we, 0);
    check("b2_rd_addr", bus.tbl_addr, 8);
    tick();
    bus.upd_valid = 1'b0;
    #1;
    check("b3_wr_we", bus.tbl_we, 1);
    check("b3_wr_addr", bus.tbl_addr, 8);
    check("b3_wr_data", bus.tbl_wdata, 2'b00);
    check("b3_ready", bus.lookup_ready, 0);
    check("b3_drop", bus.drop_cnt, 1);
    check("b3_mispred", bus.mispred_cnt, 2);
    check("b3_rsp_valid", bus.lookup_rsp_valid, 0);
    tick(); #1;
    check("b4_ready", bus.lookup_ready, 1);
    check("b4_addr", bus.tbl_addr, 5);
    check("b4_we", bus.tbl_we, 0);
    tick();
    bus.lookup_valid = 1'b0;
    #1;
    check("b5_rsp_valid", bus.lookup_rsp_valid, 1);
    check("b5_rd_addr", bus.tbl_addr, 8);
    check("b5_rd_we", bus.tbl_we, 0);
    tick(); #1;
    check("b6_wr_we", bus.tbl_we, 1);
    check("b6_wr_floor", bus.tbl_wdata, 2'b00);
    tick(); #1;
    check("b7_idle_en", bus.tbl_en, 0);

    // Reset in the cycle after an update read cancels the pending write
    tick();
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = 32'h14;
    bus.upd_taken   = 1'b0;
    bus.upd_mispred = 1'b1;
    #1;
    check("d0_idle_en", bus.tbl_en, 0);
    tick();
    bus.upd_valid   = 1'b0;
    bus.upd_mispred = 1'b0;
    #1;
    check("d1_rd_en", bus.tbl_en, 1);
    check("d1_rd_addr", bus.tbl_addr, 5);
    check("d1_mispred", bus.mispred_cnt, 3);
    tick();
    rst = 1'b1;
    #1;
    check("d2_no_write", bus.tbl_we, 0);
    check("d2_no_en", bus.tbl_en, 0);
    tick();
    rst = 1'b0;
    bus.upd_valid   = 1'b1;  // arrives during INIT: dropped but counted
    bus.upd_mispred = 1'b1;
    #1;
    check("d3_addr0", bus.tbl_addr, 0);
    check("d3_we", bus.tbl_we, 1);
    check("d3_wdata", bus.tbl_wdata, 2'b01);
    check("d3_mispred0", bus.mispred_cnt, 0);
    check("d3_drop0", bus.drop_cnt, 0);
    check("d3_init_done", bus.init_done, 0);
    check("d3_rsp_valid", bus.lookup_rsp_valid, 0);
    check("d3_ready", bus.lookup_ready, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      if (i == 1) begin
        bus.upd_valid   = 1'b0;
        bus.upd_mispred = 1'b0;
      end
      #1;
      check("resweep_addr", bus.tbl_addr, i);
      check("resweep_we", bus.tbl_we, 1);
      if (i == 1) begin
        check("init_drop", bus.drop_cnt, 1);
        check("init_mispred", bus.mispred_cnt, 1);
      end
    end
    tick(); #1;
    check("resweep_done", bus.init_done, 1);
    check("fifo_empty_idle", bus.tbl_en, 0);
    tick();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h14;
    #1;
    check("post_lk_addr", bus.tbl_addr, 5);
    tick();
    bus.lookup_valid = 1'b0;
    #1;
    check("post_lk_state", bus.lookup_rsp_state, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_port_arbiter.md
BHT_PORT_ARBITER -- requirements
Module: bht_port_arbiter

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning table index width; the table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2].
REQ-002 The block SHALL have parameter INIT_STATE, default 2'b01 (weakly not-taken), meaning the value written to every entry during initialisation.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning update FIFO depth in entries.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port lookup_valid, input, 1 bit, meaning an IF-stage prediction read is requested.
REQ-007 The block SHALL have port lookup_pc, input, 32 bits, meaning the fetch PC.
REQ-008 The block SHALL have port lookup_ready, output, 1 bit, combinational, meaning the lookup is granted this cycle.
REQ-009 The block SHALL have ports lookup_rsp_valid, output, 1 bit; lookup_rsp_taken, output, 1 bit; and lookup_rsp_state, output, 2 bits, meaning the registered lookup result.
REQ-010 The block SHALL have ports upd_valid, input, 1 bit; upd_pc, input, 32 bits; upd_taken, input, 1 bit; and upd_mispred, input, 1 bit, meaning an EX-stage branch resolution.
REQ-011 The block SHALL have ports tbl_en, output, 1 bit; tbl_we, output, 1 bit; tbl_addr, output, IDX_W bits; tbl_wdata, output, 2 bits; and tbl_rdata, input, 2 bits, meaning the single-port table interface with synchronous read and 1-cycle latency.
REQ-012 The block SHALL have port init_done, output, 1 bit, meaning the table sweep is complete.
REQ-013 The block SHALL have ports mispred_cnt, output, 16 bits, and drop_cnt, output, 8 bits, meaning statistics counters.

Function
REQ-014 The block SHALL implement the FSM states INIT and RUN, with rst forcing INIT and sweep address 0.
REQ-015 In INIT, the block SHALL drive tbl_en=1, tbl_we=1, tbl_addr=sweep and tbl_wdata=INIT_STATE, incrementing sweep each cycle; after the write to address 2^IDX_W-1 it SHALL go to RUN with init_done=1.
REQ-016 In INIT, lookup_ready SHALL be 0, and any upd_valid SHALL be dropped and counted in drop_cnt.
REQ-017 In RUN, exactly one table operation SHALL be issued per cycle, using the priority order (a) pending RMW write, (b) lookup, (c) update RMW read.
REQ-018 lookup_ready SHALL equal RUN AND no pending write AND FIFO not full, so a full FIFO blocks lookups to prevent update starvation.
REQ-019 On a lookup grant, the block SHALL drive tbl_en=1, tbl_we=0, tbl_addr=lookup_pc[IDX_W+1:2]; in the next cycle, lookup_rsp_valid=1, lookup_rsp_state=tbl_rdata and lookup_rsp_taken=tbl_rdata[1]; otherwise lookup_rsp_valid=0.
REQ-020 On an update read grant, the block SHALL read the FIFO head index, and in the next cycle it SHALL write the new value to the same index (pending write) and pop the head.
REQ-021 The new value SHALL be computed as a saturating 2-bit counter: taken gives min(old+1,3); not-taken gives max(old-1,0).
REQ-022 An update read-modify-write SHALL be atomic: nothing else uses the port between its read and write, so same-index updates serialise correctly.
REQ-023 A lookup to an index with a queued, unwritten update SHALL return the stale value; this is accepted behaviour.
REQ-024 upd_valid in RUN SHALL push {index, upd_taken} if the FIFO is not full or a pop occurs in the same cycle; otherwise the update SHALL be dropped and drop_cnt incremented.
REQ-025 drop_cnt SHALL saturate at 255.
REQ-026 upd_valid AND upd_mispred SHALL increment mispred_cnt, which wraps modulo 2^16, independently of whether the update is dropped.
REQ-027 With no operation granted, tbl_en SHALL be 0, and tbl_we and tbl_wdata are don't-care.

Reset
REQ-028 rst, in any state including mid-RMW, SHALL cancel any pending write (no table write in the following cycle), empty the FIFO, clear mispred_cnt, drop_cnt, lookup_rsp_valid and init_done, and restart the sweep at address 0.
REQ-029 After rst deasserts, the sweep SHALL take exactly 2^IDX_W cycles, and init_done SHALL rise in the cycle after the last sweep write.

Verification
REQ-030 Bench SHALL cover: rst for 1 cycle, then release -> writes of 2'b01 to addresses 0..15 on 16 consecutive cycles; lookup_ready=0 throughout; init_done=1 on the 17th cycle.
REQ-031 Bench SHALL cover: after init, lookup_valid with lookup_pc=0x14 -> tbl_addr=5, tbl_we=0; next cycle lookup_rsp_valid=1, state=2'b01, taken=0.
REQ-032 Bench SHALL cover: three taken updates to pc 0x14 with no lookups -> written values 2'b10, 2'b11, 2'b11 (saturation), each write exactly 1 cycle after its read.
REQ-033 Bench SHALL cover: lookup_valid held high with updates on 3 consecutive cycles -> lookup_ready=0 once the FIFO is full; the 3rd push without a same-cycle pop gives drop_cnt=1; two upd_mispred=1 give mispred_cnt=2.
REQ-034 Bench SHALL cover: rst asserted in the cycle after an update read -> tbl_we=0 for that index in the next cycle; the FIFO is empty, counters read 0, and the sweep restarts at address 0.
